// File: rtl/r2sdf_pkg.sv
// Shared types and arithmetic helpers for the radix-2 SDF FFT stage.
// Helpers work on a wide signed carrier (MAX_W+1 bits) and take the target
// width as an argument, so any DATA_WIDTH up to MAX_W can use them.
package r2sdf_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int MAX_W      = 32;

    typedef logic signed [MAX_W:0] wide_t;

    // Complex word at the default data width, used by stage-chain glue.
    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    // Frame-phase counter width: counts 0 .. 2*DEPTH-1.
    function automatic int cnt_w(input int depth);
        return $clog2(2 * depth);
    endfunction

    // Delay-line pointer width; a single-entry line still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Clamp v into the signed range of a w-bit value.
    function automatic wide_t sat_clip(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        return sat_clip(a + b, w);
    endfunction

    function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
        return sat_clip(a - b, w);
    endfunction

    // Halve with truncation toward minus infinity.
    function automatic wide_t scale_shift(input wide_t v);
        return v >>> 1;
    endfunction

endpackage

// File: rtl/r2sdf_delay_line.sv
// Feedback delay line: DEPTH-entry register file, one combinational read and
// one write per cycle at the same pointer, cleared by reset.
module r2sdf_delay_line #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data
);

    logic [DEPTH-1:0][WORD_W-1:0] mem_q;
    logic [DEPTH-1:0][WORD_W-1:0] mem_d;

    assign rd_data = mem_q[ptr];

    // Next contents: overwrite the addressed entry when writing.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[ptr] = wr_data;
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mem_q <= '0;
        else      mem_q <= mem_d;
    end

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage with internal frame counter.
// Fill phase stores inputs and emits pending differences; butterfly phase
// emits sums and stores differences. SCALE=1 halves, SCALE=0 saturates.
// Optional drain feature: define R2SDF_FLUSH_EN to add flush/busy ports.
module r2sdf_stage
    import r2sdf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int SCALE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_sof
`ifdef R2SDF_FLUSH_EN
    ,
    input  logic                  flush,
    output logic                  busy
`endif
);

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int WORD_W = 2 * DATA_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] samp_t;

    // Growth handling for d + x.
    function automatic samp_t g_add(input samp_t a, input samp_t b);
        wide_t r;
        if (SCALE != 0) r = scale_shift(wide_t'(a) + wide_t'(b));
        else            r = sat_add(wide_t'(a), wide_t'(b), DATA_WIDTH);
        return r[DATA_WIDTH-1:0];
    endfunction

    // Growth handling for d - x.
    function automatic samp_t g_sub(input samp_t a, input samp_t b);
        wide_t r;
        if (SCALE != 0) r = scale_shift(wide_t'(a) - wide_t'(b));
        else            r = sat_sub(wide_t'(a), wide_t'(b), DATA_WIDTH);
        return r[DATA_WIDTH-1:0];
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    samp_t            out_re_q, out_re_d;
    samp_t            out_im_q, out_im_d;

    logic             phase;
    logic [PTR_W-1:0] ptr;
    logic             step;
    samp_t            x_re, x_im;
    samp_t            d_re, d_im;
    samp_t            wr_re, wr_im;
    logic             wr_en;
    logic [WORD_W-1:0] rd_word;

    // Power-of-two frame: the top counter bit is the phase.
    assign phase = cnt_q[CNT_W-1];

    if (DEPTH > 1) begin : g_ptr
        assign ptr = cnt_q[PTR_W-1:0];
    end else begin : g_ptr_one
        assign ptr = 1'b0;
    end

    assign d_re = rd_word[WORD_W-1:DATA_WIDTH];
    assign d_im = rd_word[DATA_WIDTH-1:0];

`ifdef R2SDF_FLUSH_EN
    logic busy_q, busy_d;
    logic pend_q, pend_d;
    logic latch;

    // Drain steps feed zero unless a real sample arrives.
    assign step = in_valid | busy_q;
    assign x_re = in_valid ? samp_t'(in_re) : '0;
    assign x_im = in_valid ? samp_t'(in_im) : '0;
    assign busy = busy_q;

    // A drain starts only at a frame boundary with differences pending and
    // no live sample this cycle, so the drain covers exactly the fill slots.
    assign latch = (flush | pend_q) && (cnt_q == '0) && primed_q && !busy_q && !in_valid;

    // Flush request capture and drain tracking.
    always_comb begin
        busy_d = busy_q;
        pend_d = pend_q;
        if (latch) begin
            busy_d = 1'b1;
            pend_d = 1'b0;
        end else if (flush) begin
            pend_d = 1'b1;
        end
        if (busy_q && cnt_q == CNT_W'(DEPTH - 1)) busy_d = 1'b0;
    end

    // Drain state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end
`else
    assign step = in_valid;
    assign x_re = samp_t'(in_re);
    assign x_im = samp_t'(in_im);
`endif

    r2sdf_delay_line #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .PTR_W  (PTR_W)
    ) u_dl (
        .clk     (clk),
        .rst     (rst),
        .ptr     (ptr),
        .wr_en   (wr_en),
        .wr_data ({wr_re, wr_im}),
        .rd_data (rd_word)
    );

    // Per-step datapath: fill stores input / emits difference, butterfly
    // emits sum / stores difference. Idle cycles hold data, drop valid.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        wr_en       = 1'b0;
        wr_re       = x_re;
        wr_im       = x_im;
        if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            wr_en = 1'b1;
            if (!phase) begin
                out_valid_d = primed_q;
                if (primed_q) begin
                    out_re_d = d_re;
                    out_im_d = d_im;
                end
            end else begin
                out_re_d    = g_add(d_re, x_re);
                out_im_d    = g_add(d_im, x_im);
                wr_re       = g_sub(d_re, x_re);
                wr_im       = g_sub(d_im, x_im);
                out_valid_d = 1'b1;
                primed_d    = 1'b1;
                out_sof_d   = (ptr == '0);
            end
        end
`ifdef R2SDF_FLUSH_EN
        // Last drain step: everything emitted, restart from a clean frame.
        if (busy_q && cnt_q == CNT_W'(DEPTH - 1)) begin
            cnt_d    = '0;
            primed_d = 1'b0;
        end
`endif
    end

    // Counter, priming flag and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Bench for r2sdf_stage: two instances (saturating and halving) share one
// stimulus stream; a frame-level model predicts every output cycle.
module tb_r2sdf_stage;

    localparam int DW = 16;
    localparam int D  = 4;
    localparam int N  = 2 * D;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [DW-1:0] in_re, in_im;
    logic ov0, ov1, osof0, osof1;
    logic [DW-1:0] ore0, oim0, ore1, oim1;
`ifdef R2SDF_FLUSH_EN
    logic flush;
    logic busy0, busy1;
`endif

    always #5 clk = ~clk;

    r2sdf_stage #(.DATA_WIDTH(DW), .DEPTH(D), .SCALE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(ov0), .out_re(ore0), .out_im(oim0), .out_sof(osof0)
`ifdef R2SDF_FLUSH_EN
        , .flush(flush), .busy(busy0)
`endif
    );

    r2sdf_stage #(.DATA_WIDTH(DW), .DEPTH(D), .SCALE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(ov1), .out_re(ore1), .out_im(oim1), .out_sof(osof1)
`ifdef R2SDF_FLUSH_EN
        , .flush(flush), .busy(busy1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model (frame level) ----------------
    int pos;
    bit primed;
    int xr[N], xi[N];
    int dr[2][D], di[2][D];
    bit ev[2], es[2], nev[2], nes[2];
    int er[2], ei[2], ner[2], nei[2];
    bit eb, neb;
    int mq0[$];
    int obs0[$], obs1[$];

    function automatic int g(input int v, input int s);
        if (s != 0) return v >>> 1;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model_reset();
        pos = 0; primed = 0;
        for (int k = 0; k < N; k++) begin xr[k] = 0; xi[k] = 0; end
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < D; k++) begin dr[s][k] = 0; di[s][k] = 0; end
            ev[s] = 0; es[s] = 0; er[s] = 0; ei[s] = 0;
            nev[s] = 0; nes[s] = 0; ner[s] = 0; nei[s] = 0;
        end
        eb = 0; neb = 0;
    endtask

    // Predict the registered outputs produced by one accepted sample.
    task automatic model_step(input int r, input int i);
        int q;
        for (int s = 0; s < 2; s++) begin
            nes[s] = 0;
            if (pos < D) begin
                nev[s] = primed;
                if (primed) begin ner[s] = dr[s][pos]; nei[s] = di[s][pos]; end
            end else begin
                q = pos - D;
                nev[s] = 1;
                ner[s] = g(xr[q] + r, s);
                nei[s] = g(xi[q] + i, s);
                dr[s][q] = g(xr[q] - r, s);
                di[s][q] = g(xi[q] - i, s);
                nes[s] = (q == 0);
            end
        end
        if (pos < D) begin xr[pos] = r; xi[pos] = i; end
        else primed = 1;
        pos = (pos + 1) % N;
    endtask

    // One clock: drive inputs, predict, commit expectations after the edge.
    task automatic cyc(input bit v, input int r, input int i);
        in_valid = v;
        in_re = DW'(r);
        in_im = DW'(i);
        if (v) model_step(r, i);
        else begin nev[0] = 0; nev[1] = 0; nes[0] = 0; nes[1] = 0; end
        @(posedge clk);
        ev = nev; es = nes; er = ner; ei = nei; eb = neb;
        if (nev[0]) mq0.push_back(ner[0]);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
        obs0.delete(); obs1.delete(); mq0.delete();
    endtask

    // ---------------- single compare process ----------------
    task automatic check(input int s, input logic v, input logic [DW-1:0] r,
                         input logic [DW-1:0] i, input logic sof);
        int ar, ai;
        ar = int'($signed(r));
        ai = int'($signed(i));
        n_tests++;
        if (v !== ev[s] || sof !== es[s] || ar != er[s] || ai != ei[s] || $isunknown({v, sof, r, i})) begin
            n_fail++;
            $display("FAIL out_s%0d @%0t: got v=%b re=%0d im=%0d sof=%b, want v=%b re=%0d im=%0d sof=%b",
                     s, $time, v, ar, ai, sof, ev[s], er[s], ei[s], es[s]);
        end
        if (v === 1'b1) begin
            if (s == 0) obs0.push_back(ar);
            else        obs1.push_back(ar);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check(0, ov0, ore0, oim0, osof0);
            check(1, ov1, ore1, oim1, osof1);
`ifdef R2SDF_FLUSH_EN
            n_tests++;
            if (busy0 !== eb || busy1 !== eb) begin
                n_fail++;
                $display("FAIL busy @%0t: got %b/%b want %b", $time, busy0, busy1, eb);
            end
`endif
        end
    end

    // Compare a captured stream against a hand-computed literal sequence.
    task automatic chk_seq(input string nm, input int got[$], input int want[8], input int len);
        int bad;
        bad = -1;
        n_tests++;
        if (got.size() != len) bad = len;
        else for (int k = 0; k < len; k++) if (bad < 0 && got[k] != want[k]) bad = k;
        if (bad >= 0) begin
            n_fail++;
            if (bad < got.size() && bad < len)
                $display("FAIL %s: index %0d got %0d want %0d", nm, bad, got[bad], want[bad]);
            else
                $display("FAIL %s: got %0d outputs want %0d", nm, got.size(), len);
        end
    endtask

    task automatic feed_ramp(input bit gapped);
        for (int k = 1; k <= 8; k++) begin
            cyc(1, k, 0);
            if (gapped) cyc(0, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            if (gapped) cyc(0, 0, 0);
        end
        cyc(0, 0, 0);
    endtask

    int w_ramp0[8] = '{6, 8, 10, 12, -4, -4, -4, -4};
    int w_ramp1[8] = '{3, 4, 5, 6, -2, -2, -2, -2};
    int w_sat0[8]  = '{32767, -1, 7, 0, 0, -32768, -1, 0};
    int w_sat1[8]  = '{32767, -1, 3, 0, 0, -32768, -1, 0};
    int w_drain[8] = '{-4, -4, -4, -4, 0, 0, 0, 0};
    int sat_in[12] = '{32767, -32768, 3, 0, 32767, 32767, 4, 0, 0, 0, 0, 0};

    initial begin
        logic [DW-1:0] t0, t1;
        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
`ifdef R2SDF_FLUSH_EN
        flush = 1'b0;
`endif
        model_reset();
        #1 chk_en = 1'b1;
        do_reset(2);

        // Ramp, back to back.
        feed_ramp(1'b0);
        chk_seq("ramp_model", mq0, w_ramp0, 8);
        chk_seq("ramp_s0", obs0, w_ramp0, 8);
        chk_seq("ramp_s1", obs1, w_ramp1, 8);

        // Saturation and halving corner pairs.
        do_reset(2);
        for (int k = 0; k < 12; k++) cyc(1, sat_in[k], 0);
        cyc(0, 0, 0);
        chk_seq("sat_model", mq0, w_sat0, 8);
        chk_seq("sat_s0", obs0, w_sat0, 8);
        chk_seq("sat_s1", obs1, w_sat1, 8);

        // Gapped in_valid.
        do_reset(2);
        feed_ramp(1'b1);
        chk_seq("gap_s0", obs0, w_ramp0, 8);
        chk_seq("gap_s1", obs1, w_ramp1, 8);

        // Reset in the middle of a frame.
        do_reset(2);
        for (int k = 0; k < 6; k++) cyc(1, 100 + k, 7);
        do_reset(3);
        feed_ramp(1'b0);
        chk_seq("midrst_s0", obs0, w_ramp0, 8);

`ifdef R2SDF_FLUSH_EN
        // Drain the last frame's differences with flush.
        do_reset(2);
        for (int k = 1; k <= 8; k++) cyc(1, k, 0);
        flush = 1'b1;
        neb = 1;
        cyc(0, 0, 0);
        flush = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (k == D - 1) neb = 0;
            cyc(1'b1, 0, 0);
            in_valid = 1'b0;
        end
        primed = 0; pos = 0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        obs0 = obs0[4:$];
        chk_seq("drain_s0", obs0, w_drain, 4);
`endif

        // Randomized traffic, including full-scale values.
        do_reset(2);
        for (int k = 0; k < 600; k++) begin
            t0 = DW'($urandom);
            t1 = DW'($urandom);
            if ($urandom_range(0, 3) == 0) t0 = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            cyc($urandom_range(0, 9) < 7, int'($signed(t0)), int'($signed(t1)));
        end
        cyc(0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
